// File: rtl/wide_add_pkg.sv
// Shared constants for the nibble-serial wide adder.
// State encoding, slice width and counter-width helper.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / NIBBLE_W);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_4bit.sv
// Four-bit ripple-carry adder slice.
// Shared by the sequencer across all nibbles.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Nibble-serial wide adder: one adder_4bit stepped LSB to MSB.
// Optional subtract mode when SEQ_SUB_EN is defined.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [NIBBLE_W-1:0] s_a;
    logic [NIBBLE_W-1:0] s_b;
    logic [NIBBLE_W-1:0] s_sum;
    logic                s_cout;
    logic                carry_init;

`ifdef SEQ_SUB_EN
    logic sub_q, sub_d;
    // Two's-complement subtract: invert b and force the initial carry.
    assign s_b        = b_q[cnt_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign s_b        = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];
    assign carry_init = cin;
`endif

    assign s_a = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];

    adder_4bit u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    carry_d = carry_init;
`ifdef SEQ_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = s_sum;
                carry_d = s_cout;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = s_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide adder controller that shares one `adder_4bit` ripple-carry slice across all nibbles of a WIDTH-bit operand pair. It accepts operands over a valid/ready handshake and steps the slice through the nibbles from LSB to MSB, registering the carry between steps. It returns the full sum and final carry over a second valid/ready handshake. It sits between a requester (sequencer or CPU-side register block) and any consumer of wide sums, trading latency for area.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- sub  input  1  subtract request (present only with SEQ_SUB_EN)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB nibble

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid && in_ready`, latch `a`, `b`, `cin` (and `sub`).
  - Clear the nibble counter and the sum register.
  - Load the carry register with `cin`, then go to RUN.
- RUN: each cycle, the slice adds `a_reg[4k+3:4k]` + `b_reg[4k+3:4k]` + carry, where k is the counter value.
  - Write the slice sum into `sum[4k+3:4k]` and load the carry register with the slice cout.
  - Increment k.
  - When k = WIDTH/4-1, k wraps to 0, `cout` takes the final carry, and the state goes to DONE.
- DONE: `out_valid`=1; `sum` and `cout` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` in RUN or DONE is ignored; nothing is queued.
- Arithmetic: the result is (a + b + cin) mod 2^WIDTH, with `cout` as bit WIDTH. There is no overflow flag.
- Reset, at any time including mid-RUN or DONE:
  - State goes to IDLE, counter and carry to 0, `sum`=0, `cout`=0, `out_valid`=0.
  - `in_ready`=1 after reset deasserts.
  - An aborted operation produces no result.

## Timing
- Acceptance edge = E0. The state is RUN from E0 to E(N), where N = WIDTH/4.
- `out_valid` rises at edge E(N), which is 4 cycles for WIDTH=16.
- The output handshake completes at the first edge with `out_valid && out_ready`. The state is IDLE after that edge.
- The next acceptance is possible at the following edge, so minimum issue interval = N+2 cycles.
- All outputs are registered. There is no combinational path from input to output.
- `sum` nibbles are updated progressively during RUN. They are valid only while `out_valid`=1.

## Configuration
- SEQ_SUB_EN defined:
  - The `sub` port exists. `sub` is latched at acceptance.
  - When latched `sub`=1, every b nibble is inverted before the slice, the initial carry is forced to 1, and `cin` is ignored.
  - The result is (a − b) mod 2^WIDTH. `cout`=1 means no borrow.
- SEQ_SUB_EN undefined: the `sub` port is absent and the block is add-only.

## Structure
- Package `wide_add_pkg` contains:
  - state encoding constants (IDLE/RUN/DONE);
  - the NIBBLE_W=4 constant;
  - a function returning the counter width, clog2(WIDTH/4), minimum 1.
- One sub-module: the existing `adder_4bit`, instantiated once. Its port map is a, b, cin, sum, cout.
- The counter, carry register, operand registers and FSM live in `wide_add_sequencer`.

## Test plan
All scenarios use WIDTH=16 unless noted.
1. a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0; `out_valid` exactly 4 edges after acceptance.
2. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Checks that the carry ripples through all 4 nibbles.
3. Backpressure: result a=0x1234+b=0x1111 (sum 0x2345), with `out_ready` held low 5 cycles.
   - `out_valid`=1, `sum`=0x2345 and `in_ready`=0 stay stable throughout.
   - A new `in_valid` in that window is ignored.
4. Reset pulse during the second RUN cycle → `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=1.
   - A subsequent a=0x1234, b=0x1111, cin=0 gives 0x2345.
5. SEQ_SUB_EN subtract cases:
   - 0x0007−0x0005 → sum=0x0002, cout=1.
   - 0x0005−0x0007 → sum=0xFFFE, cout=0.
6. Back-to-back: with `in_valid` held high and `out_ready` tied to 1, successive acceptances are 6 cycles apart. Results match a reference model over 200 random operand pairs.
